polyphase_mac_sequencer: RTL and testbench
==========================================

// Module: polyphase_mac_sequencer
// PURPOSE
//  Sequences the shared multiply-accumulate datapath of the interpolating FIR as a polyphase filter.
//  On each input sample it writes the sample into the circular sample buffer.
//  It then runs L phases. Each phase clears the accumulator and streams PHASE_TAPS coefficient/sample address
//  pairs, waits for the pipeline to drain, then pulses sample_rdy.
//  Sits between the input strobe (Data_RDY) and the coefficient ROM, sample RAM and MAC/accumulator.
// PARAMETERS
//  TAPS       199  total prototype filter taps
//  L          8    interpolation factor (number of phases)
//  PHASE_TAPS 25   taps per phase = ceil(TAPS/L); also sample-buffer depth
//  ADDR_W     8    coef_addr width; must hold PHASE_TAPS*L-1
//  BUF_W      5    buffer address width; must hold PHASE_TAPS-1
//  PIPE_LAT   3    cycles from last mac_en to valid accumulator output
// PORTS
//  CLOCK      in   1       system clock, rising edge
//  RESET      in   1       synchronous, active-high
//  Data_RDY   in   1       new input sample strobe, one cycle
//  sample_we  out  1       write current input sample to buffer at wr_ptr
//  wr_ptr     out  BUF_W   buffer write address
//  buf_addr   out  BUF_W   buffer read address for current tap
//  coef_addr  out  ADDR_W  coefficient ROM address = tap*L + phase
//  mac_en     out  1       multiply-accumulate enable for this tap
//  acc_clr    out  1       clear accumulator
//  sample_rdy out  1       accumulator holds a valid output sample, one cycle
//  phase      out  3       current phase index 0..L-1
//  busy       out  1       high in every state except IDLE
//  overrun    out  1       sticky: input sample dropped (see CONFIGURATION)
// BEHAVIOUR
//  All outputs are registered and Moore-decoded. On reset all outputs are 0; wr_ptr=0, phase=0, state=IDLE, pending=0.
//  States and transitions:
//   IDLE  -> WRITE when Data_RDY.
//   WRITE -> CLEAR. sample_we=1; phase<=0; newest<=wr_ptr; wr_ptr increments mod PHASE_TAPS on exit.
//   CLEAR -> MAC. acc_clr=1; tap<=0; coef_addr<=phase; buf_addr<=newest.
//   MAC   -> DRAIN after PHASE_TAPS cycles (tap 0..PHASE_TAPS-1).
//            Each cycle coef_addr+=L; buf_addr decrements, wrapping 0->PHASE_TAPS-1.
//            mac_en=1 only when coef_addr<TAPS (zero-pad; e.g. phase 7, tap 24, addr 199).
//   DRAIN -> EMIT after PIPE_LAT cycles.
//   EMIT  -> sample_rdy=1. If phase<L-1: phase++ and go to CLEAR.
//            Else go to WRITE if pending (clear pending), otherwise go to IDLE.
//  Latency: first sample_rdy comes 31 cycles after Data_RDY.
//   Phase period is 2+PHASE_TAPS+PIPE_LAT = 30 cycles; the full sample takes 241 cycles to its last sample_rdy.
//  Data_RDY while busy (any state except IDLE, including the final EMIT) sets the one-deep pending flag.
//   A further Data_RDY while pending is set is dropped.
//  RESET mid-operation aborts immediately: no sample_rdy, buffer contents untouched, wr_ptr returns to 0.
// CONFIGURATION
//  OVERRUN_DETECT_EN defined: overrun goes to 1 the cycle after a dropped Data_RDY.
//   It stays 1 until RESET.
//  Not defined: overrun is tied to 0 and no detection logic is built. Drop behaviour is otherwise identical.
// STRUCTURE
//  fir_ctrl_pkg.vh: state encodings, default TAPS/L/PIPE_LAT, PHASE_TAPS derivation macro.
//  Sub-module mod_counter (up/down, load, wrap at PHASE_TAPS-1). It is instantiated for wr_ptr and buf_addr.
// TESTING
//  Reset, one Data_RDY at cycle 0 -> sample_we at 1; acc_clr at 2; sample_rdy at 31,61,...,241; busy=0 at 242.
//  Phase 3 -> coef_addr 3,11,...,195, all with mac_en=1.
//   Phase 7 -> last tap coef_addr 199 with mac_en=0.
//  26 samples -> wr_ptr wraps 24->0. Sample at ptr 0: buf_addr 0,24,23,...,1.
//  Data_RDY at cycle 100 of a sample -> no IDLE; WRITE at cycle 242; phase restarts at 0.
//  Data_RDY at cycles 100 and 150 -> second dropped.
//   overrun=1 from cycle 151 with OVERRUN_DETECT_EN; 0 without.
//  RESET at cycle 50 -> cycle 51: all outputs 0, state IDLE, no further sample_rdy.
//   Next Data_RDY writes at wr_ptr 0.

Source files
------------

// File: rtl/polyphase_mac_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// polyphase_mac_sequencer_pkg : state encoding and default filter geometry
// Rev 1.0
// ============================================================================
package polyphase_mac_sequencer_pkg;

    localparam int DEF_TAPS     = 199;
    localparam int DEF_L        = 8;
    localparam int DEF_PIPE_LAT = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_CLEAR = 3'd2,
        S_MAC   = 3'd3,
        S_DRAIN = 3'd4,
        S_EMIT  = 3'd5
    } state_e;

    function automatic int phase_taps(input int taps, input int l);
        return (taps + l - 1) / l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/polyphase_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
// polyphase_mac_sequencer_if : strobe in, buffer/ROM/MAC controls out
// Rev 1.0
// ============================================================================
interface polyphase_mac_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int BUF_W  = 5
);
    logic              Data_RDY;
    logic              sample_we;
    logic [BUF_W-1:0]  wr_ptr;
    logic [BUF_W-1:0]  buf_addr;
    logic [ADDR_W-1:0] coef_addr;
    logic              mac_en;
    logic              acc_clr;
    logic              sample_rdy;
    logic [2:0]        phase;
    logic              busy;
    logic              overrun;

    modport master (
        input  Data_RDY,
        output sample_we, wr_ptr, buf_addr, coef_addr, mac_en,
               acc_clr, sample_rdy, phase, busy, overrun
    );

    modport slave (
        output Data_RDY,
        input  sample_we, wr_ptr, buf_addr, coef_addr, mac_en,
               acc_clr, sample_rdy, phase, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/polyphase_mac_sequencer_mod_counter.sv
`default_nettype none
// ============================================================================
// mod_counter : loadable up/down counter wrapping between 0 and MOD-1
// Rev 1.0
// ============================================================================
module mod_counter #(
    parameter int MOD = 25,
    parameter int W   = 5
) (
    input  wire logic         CLOCK,
    input  wire logic         RESET,
    input  wire logic         ld_i,
    input  wire logic [W-1:0] ld_val_i,
    input  wire logic         en_i,
    input  wire logic         up_i,
    output logic      [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            if (up_i) begin
                cnt_d = (cnt_q == W'(MOD - 1)) ? '0 : cnt_q + 1'b1;
            end else begin
                cnt_d = (cnt_q == '0) ? W'(MOD - 1) : cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule
`default_nettype wire

// File: rtl/polyphase_mac_sequencer.sv
`default_nettype none
// ============================================================================
// polyphase_mac_sequencer : drives shared MAC through L phases per input sample
// Optional feature macro: OVERRUN_DETECT_EN (sticky dropped-strobe flag)
// Rev 1.0
// ============================================================================
module polyphase_mac_sequencer
    import polyphase_mac_sequencer_pkg::*;
#(
    parameter int TAPS       = DEF_TAPS,
    parameter int L          = DEF_L,
    parameter int PHASE_TAPS = phase_taps(DEF_TAPS, DEF_L),
    parameter int ADDR_W     = 8,
    parameter int BUF_W      = 5,
    parameter int PIPE_LAT   = DEF_PIPE_LAT
) (
    input  wire logic                  CLOCK,
    input  wire logic                  RESET,
    polyphase_mac_sequencer_if.master  bus
);
    localparam int CNT_W = $clog2((PHASE_TAPS > PIPE_LAT) ? PHASE_TAPS : PIPE_LAT);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          phase_q, phase_d;
    logic [BUF_W-1:0]    newest_q, newest_d;
    logic [ADDR_W-1:0]   coef_q, coef_d;
    logic                pending_q, pending_d;
    logic                sample_we_q, sample_we_d;
    logic                acc_clr_q, acc_clr_d;
    logic                mac_en_q, mac_en_d;
    logic                sample_rdy_q, sample_rdy_d;
    logic                busy_q, busy_d;
    logic [BUF_W-1:0]    wr_ptr_w;
    logic [BUF_W-1:0]    buf_addr_w;

    mod_counter #(.MOD(PHASE_TAPS), .W(BUF_W)) u_wr_ptr (
        .CLOCK(CLOCK), .RESET(RESET), .ld_i(1'b0), .ld_val_i('0),
        .en_i(state_q == S_WRITE), .up_i(1'b1), .cnt_o(wr_ptr_w)
    );

    // Walks backwards from the newest sample, one slot per tap.
    mod_counter #(.MOD(PHASE_TAPS), .W(BUF_W)) u_buf_addr (
        .CLOCK(CLOCK), .RESET(RESET), .ld_i(state_q == S_CLEAR), .ld_val_i(newest_q),
        .en_i(state_q == S_MAC), .up_i(1'b0), .cnt_o(buf_addr_w)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        newest_d  = newest_q;
        coef_d    = coef_q;
        pending_d = pending_q;
        if (bus.Data_RDY && (state_q != S_IDLE)) pending_d = 1'b1;
        case (state_q)
            S_IDLE:  if (bus.Data_RDY) state_d = S_WRITE;
            S_WRITE: begin
                newest_d = wr_ptr_w;
                state_d  = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_d   = '0;
                coef_d  = ADDR_W'(phase_q);
                state_d = S_MAC;
            end
            S_MAC: begin
                coef_d = coef_q + ADDR_W'(L);
                if (cnt_q == CNT_W'(PHASE_TAPS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(PIPE_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = S_EMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (phase_q != 3'(L - 1)) begin
                    phase_d = phase_q + 1'b1;
                    state_d = S_CLEAR;
                end else if (pending_q || bus.Data_RDY) begin
                    // A strobe landing on the final EMIT is taken directly.
                    pending_d = 1'b0;
                    state_d   = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_WRITE) phase_d = '0;

        sample_we_d  = (state_d == S_WRITE);
        acc_clr_d    = (state_d == S_CLEAR);
        sample_rdy_d = (state_d == S_EMIT);
        busy_d       = (state_d != S_IDLE);
        mac_en_d     = (state_d == S_MAC) && (coef_d < ADDR_W'(TAPS));
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            phase_q      <= '0;
            newest_q     <= '0;
            coef_q       <= '0;
            pending_q    <= 1'b0;
            sample_we_q  <= 1'b0;
            acc_clr_q    <= 1'b0;
            mac_en_q     <= 1'b0;
            sample_rdy_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            newest_q     <= newest_d;
            coef_q       <= coef_d;
            pending_q    <= pending_d;
            sample_we_q  <= sample_we_d;
            acc_clr_q    <= acc_clr_d;
            mac_en_q     <= mac_en_d;
            sample_rdy_q <= sample_rdy_d;
            busy_q       <= busy_d;
        end
    end

`ifdef OVERRUN_DETECT_EN
    logic overrun_q;
    logic overrun_d;

    always_comb begin
        overrun_d = overrun_q | (bus.Data_RDY && (state_q != S_IDLE) && pending_q);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) overrun_q <= 1'b0;
        else       overrun_q <= overrun_d;
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

    assign bus.sample_we  = sample_we_q;
    assign bus.wr_ptr     = wr_ptr_w;
    assign bus.buf_addr   = buf_addr_w;
    assign bus.coef_addr  = coef_q;
    assign bus.mac_en     = mac_en_q;
    assign bus.acc_clr    = acc_clr_q;
    assign bus.sample_rdy = sample_rdy_q;
    assign bus.phase      = phase_q;
    assign bus.busy       = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_polyphase_mac_sequencer.sv
`default_nettype none
// ============================================================================
// tb_polyphase_mac_sequencer : scoreboard bench for the polyphase sequencer
// Rev 1.0
// ============================================================================
module tb_polyphase_mac_sequencer;

    typedef struct {
        int   cyc;
        int   a;
        int   b;
        logic en;
    } ev_t;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   model_ptr = 0;
    ev_t  mac_q[$];
    ev_t  rdy_q[$];
    ev_t  we_q[$];

`ifdef OVERRUN_DETECT_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    polyphase_mac_sequencer_if #(.ADDR_W(8), .BUF_W(5)) bus ();

    polyphase_mac_sequencer dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    // Scoreboard consumer: every expected event is popped on its cycle.
    always @(negedge CLOCK) begin
        if (mac_q.size() > 0 && mac_q[0].cyc == cyc) begin
            ev_t e;
            e = mac_q.pop_front();
            total++;
            if (bus.coef_addr !== 8'(e.a) || bus.buf_addr !== 5'(e.b) || bus.mac_en !== e.en) begin
                bad++;
                $display("FAIL mac_tap cyc=%0d actual coef=%0d buf=%0d en=%b required coef=%0d buf=%0d en=%b",
                         cyc, bus.coef_addr, bus.buf_addr, bus.mac_en, e.a, e.b, e.en);
            end
        end else if (bus.mac_en !== 1'b0) begin
            total++; bad++;
            $display("FAIL mac_unexpected cyc=%0d actual en=%b required en=0", cyc, bus.mac_en);
        end
        if (rdy_q.size() > 0 && rdy_q[0].cyc == cyc) begin
            void'(rdy_q.pop_front());
            total++;
            if (bus.sample_rdy !== 1'b1) begin
                bad++;
                $display("FAIL sample_rdy cyc=%0d actual=%b required=1", cyc, bus.sample_rdy);
            end
        end else if (bus.sample_rdy !== 1'b0) begin
            total++; bad++;
            $display("FAIL rdy_unexpected cyc=%0d actual=%b required=0", cyc, bus.sample_rdy);
        end
        if (we_q.size() > 0 && we_q[0].cyc == cyc) begin
            ev_t e;
            e = we_q.pop_front();
            total++;
            if (bus.sample_we !== 1'b1 || bus.wr_ptr !== 5'(e.a)) begin
                bad++;
                $display("FAIL sample_we cyc=%0d actual we=%b ptr=%0d required we=1 ptr=%0d",
                         cyc, bus.sample_we, bus.wr_ptr, e.a);
            end
        end else if (bus.sample_we !== 1'b0) begin
            total++; bad++;
            $display("FAIL we_unexpected cyc=%0d actual=%b required=0", cyc, bus.sample_we);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic at_neg(input int c);
        wait_until(c);
        @(negedge CLOCK);
    endtask

    task automatic pulse_rdy(input int c);
        wait_until(c);
        bus.Data_RDY = 1'b1;
        @(posedge CLOCK);
        #1;
        bus.Data_RDY = 1'b0;
    endtask

    // Expected trace of one sample whose WRITE cycle is w, written at ptr p.
    task automatic push_sample(input int w, input int p);
        ev_t e;
        e.cyc = w; e.a = p; e.b = 0; e.en = 1'b1;
        we_q.push_back(e);
        for (int ph = 0; ph < 8; ph++) begin
            for (int t = 0; t < 25; t++) begin
                e.cyc = w + 2 + 30 * ph + t;
                e.a   = t * 8 + ph;
                e.b   = (p - t + 25) % 25;
                e.en  = (e.a < 199);
                mac_q.push_back(e);
            end
            e.cyc = w + 30 + 30 * ph;
            rdy_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        at_neg(2);
        total++;
        if ({bus.sample_we, bus.mac_en, bus.acc_clr, bus.sample_rdy, bus.busy, bus.overrun} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags actual=%b required=000000",
                     {bus.sample_we, bus.mac_en, bus.acc_clr, bus.sample_rdy, bus.busy, bus.overrun});
        end
        total++;
        if (bus.wr_ptr !== 5'd0 || bus.buf_addr !== 5'd0) begin
            bad++;
            $display("FAIL reset_ptrs actual wr=%0d buf=%0d required 0 0", bus.wr_ptr, bus.buf_addr);
        end
        total++;
        if (bus.coef_addr !== 8'd0 || bus.phase !== 3'd0) begin
            bad++;
            $display("FAIL reset_coef_phase actual coef=%0d phase=%0d required 0 0", bus.coef_addr, bus.phase);
        end
        wait_until(3);
        RESET = 1'b0;
    endtask

    task automatic test_single();
        int c0;
        c0 = 10;
        pulse_rdy(c0);
        push_sample(c0 + 1, model_ptr);
        model_ptr = (model_ptr + 1) % 25;
        at_neg(c0 + 2);
        total++;
        if (bus.acc_clr !== 1'b1 || bus.phase !== 3'd0) begin
            bad++;
            $display("FAIL first_clear actual clr=%b phase=%0d required clr=1 phase=0", bus.acc_clr, bus.phase);
        end
        at_neg(c0 + 2 + 90);
        total++;
        if (bus.acc_clr !== 1'b1 || bus.phase !== 3'd3) begin
            bad++;
            $display("FAIL phase3_clear actual clr=%b phase=%0d required clr=1 phase=3", bus.acc_clr, bus.phase);
        end
        at_neg(c0 + 241);
        total++;
        if (bus.busy !== 1'b1 || bus.phase !== 3'd7) begin
            bad++;
            $display("FAIL last_emit actual busy=%b phase=%0d required busy=1 phase=7", bus.busy, bus.phase);
        end
        at_neg(c0 + 242);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after actual busy=%b required=0", bus.busy);
        end
    endtask

    task automatic test_wrap();
        int c;
        for (int n = 0; n < 25; n++) begin
            c = cyc + 2;
            pulse_rdy(c);
            push_sample(c + 1, model_ptr);
            model_ptr = (model_ptr + 1) % 25;
            if (n == 24) begin
                at_neg(c + 3);
                total++;
                if (bus.buf_addr !== 5'd0) begin
                    bad++;
                    $display("FAIL wrap_tap0 actual buf=%0d required=0", bus.buf_addr);
                end
                at_neg(c + 4);
                total++;
                if (bus.buf_addr !== 5'd24) begin
                    bad++;
                    $display("FAIL wrap_tap1 actual buf=%0d required=24", bus.buf_addr);
                end
            end
            wait_until(c + 243);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cyc + 2;
        pulse_rdy(c0);
        push_sample(c0 + 1, model_ptr);
        model_ptr = (model_ptr + 1) % 25;
        pulse_rdy(c0 + 100);
        push_sample(c0 + 242, model_ptr);
        model_ptr = (model_ptr + 1) % 25;
        at_neg(c0 + 242);
        total++;
        if (bus.busy !== 1'b1 || bus.phase !== 3'd0) begin
            bad++;
            $display("FAIL b2b_rewrite actual busy=%b phase=%0d required busy=1 phase=0", bus.busy, bus.phase);
        end
        wait_until(c0 + 485);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle actual busy=%b required=0", bus.busy);
        end
    endtask

    task automatic test_overrun();
        int c0;
        c0 = cyc + 2;
        pulse_rdy(c0);
        push_sample(c0 + 1, model_ptr);
        model_ptr = (model_ptr + 1) % 25;
        pulse_rdy(c0 + 100);
        push_sample(c0 + 242, model_ptr);
        model_ptr = (model_ptr + 1) % 25;
        at_neg(c0 + 150);
        total++;
        if (bus.overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_early actual=%b required=0", bus.overrun);
        end
        pulse_rdy(c0 + 150);
        at_neg(c0 + 151);
        total++;
        if (bus.overrun !== EXP_OVR) begin
            bad++;
            $display("FAIL overrun_set actual=%b required=%b", bus.overrun, EXP_OVR);
        end
        wait_until(c0 + 490);
        @(negedge CLOCK);
        total++;
        if (bus.overrun !== EXP_OVR || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL overrun_sticky actual ovr=%b busy=%b required ovr=%b busy=0",
                     bus.overrun, bus.busy, EXP_OVR);
        end
    endtask

    task automatic test_reset_abort();
        int c0;
        c0 = cyc + 2;
        pulse_rdy(c0);
        push_sample(c0 + 1, model_ptr);
        wait_until(c0 + 50);
        RESET = 1'b1;
        while (mac_q.size() > 0 && mac_q[mac_q.size() - 1].cyc > c0 + 50) void'(mac_q.pop_back());
        while (rdy_q.size() > 0 && rdy_q[rdy_q.size() - 1].cyc > c0 + 50) void'(rdy_q.pop_back());
        while (we_q.size() > 0 && we_q[we_q.size() - 1].cyc > c0 + 50) void'(we_q.pop_back());
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        model_ptr = 0;
        @(negedge CLOCK);
        total++;
        if ({bus.sample_we, bus.mac_en, bus.acc_clr, bus.sample_rdy, bus.busy, bus.overrun} !== 6'b0
            || bus.wr_ptr !== 5'd0 || bus.phase !== 3'd0 || bus.coef_addr !== 8'd0) begin
            bad++;
            $display("FAIL abort_outputs actual flags=%b wr=%0d phase=%0d coef=%0d required all 0",
                     {bus.sample_we, bus.mac_en, bus.acc_clr, bus.sample_rdy, bus.busy, bus.overrun},
                     bus.wr_ptr, bus.phase, bus.coef_addr);
        end
        pulse_rdy(c0 + 400);
        push_sample(c0 + 401, model_ptr);
        model_ptr = (model_ptr + 1) % 25;
        at_neg(c0 + 401);
        total++;
        if (bus.wr_ptr !== 5'd0) begin
            bad++;
            $display("FAIL abort_rewrite actual wr=%0d required=0", bus.wr_ptr);
        end
        wait_until(c0 + 645);
    endtask

    initial begin
        bus.Data_RDY = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_overrun();
        test_reset_abort();
        total++;
        if (mac_q.size() + rdy_q.size() + we_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", mac_q.size() + rdy_q.size() + we_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
